k_wptr_full_sync_t3: RTL and testbench
======================================

Name: k_wptr_full_sync_t3

Overview:
- Write-side pointer and flag generator for the dual-clock FIFO. It is the parametrised successor of the dual binary/Gray counter.
- Keeps binary and Gray write pointers (ADDR_SIZE+1 bits) and synchronises the read-domain Gray pointer into the write clock.
- Produces registered full, almost-full and fill-level outputs, plus the gated memory write enable.
- Sits between the write client and the dual-port RAM; the read-side twin is a separate block.

Parameters:
- ADDR_SIZE, 4, RAM address width; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- AFULL_THRESH, 12, level at or above which walmost_full asserts; legal range 1..2**ADDR_SIZE.
- SYNC_STAGES, 2, flops in the read-pointer synchroniser; minimum 2.

Ports:
- clk  input  1  write-domain clock
- rst_n  input  1  asynchronous active-low reset
- winc  input  1  write request from client
- rptr_gray  input  ADDR_SIZE+1  read-domain Gray pointer (asynchronous to clk)
- wen  output  1  RAM write strobe = winc & ~wfull (combinational)
- waddr  output  ADDR_SIZE  RAM write address = wbin[ADDR_SIZE-1:0]
- wptr_gray  output  ADDR_SIZE+1  registered Gray write pointer, to read domain
- wfull  output  1  registered full flag
- walmost_full  output  1  registered almost-full flag
- wlevel  output  ADDR_SIZE+1  registered occupancy as seen by the write side, 0..2**ADDR_SIZE
- wovf  output  1  sticky overflow flag; present only with K_WPTR_OVF_EN
- wovf_clr  input  1  clears wovf; present only with K_WPTR_OVF_EN

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low.
  - At rst_n low: wbin, wptr_gray, all synchroniser flops, wlevel, wfull, walmost_full and wovf go to 0.
  - The synchroniser resets to Gray 0.
- Accept: a write is accepted when winc && !wfull; wen is high in that cycle.
- Next-pointer rules:
  - wbin_nxt = wbin + (winc && !wfull), modulo 2**(ADDR_SIZE+1).
  - wgray_nxt = (wbin_nxt>>1) ^ wbin_nxt.
  - Both pointers register on the next rising edge, so there is 1 cycle from the accepted winc to wptr_gray/waddr advancing.
- Synchroniser: rq[0] <= rptr_gray, then rq[i] <= rq[i-1]. rq_sync = rq[SYNC_STAGES-1]. No logic sits between stages.
- Full:
  - wfull <= (wgray_nxt == {~rq_sync[MSB:MSB-1], rq_sync[MSB-2:0]}).
  - The flag asserts in the same cycle the last slot is written, so there is no extra-write window.
  - The flag deasserts SYNC_STAGES+1 cycles after the read pointer moves; this pessimism is accepted.
- Level:
  - rbin_sync = Gray-to-binary of rq_sync.
  - wlevel <= wbin_nxt - rbin_sync, taken in ADDR_SIZE+1 bits with modulo arithmetic.
  - When wfull is registered high, wlevel is 2**ADDR_SIZE.
- Almost full: walmost_full <= (wbin_nxt - rbin_sync) >= AFULL_THRESH. It uses the same registered timing as wfull.
- Wrap-around: wbin rolls from 2**(ADDR_SIZE+1)-1 to 0; the MSB toggle distinguishes full from empty. waddr wraps at depth.
- winc while wfull: the request is ignored. Pointers hold and wen stays 0.
- Simultaneous write and read-pointer change: flags use the newly synchronised value from that edge. No combinational path from rptr_gray to any output.
- Reset mid-operation: all state returns to the reset values immediately and asynchronously. A partially synchronised read pointer is discarded.

Optional Feature:
- Macro: K_WPTR_OVF_EN.
- Defined:
  - wovf sets on any cycle with winc && wfull.
  - wovf clears on wovf_clr; set wins when both are high in the same cycle.
  - Reset value 0.
- Undefined: the wovf and wovf_clr ports and their logic are absent. Overflowing writes are silently dropped.

Decomposition:
- Shared package k_fifo_pkg:
  - default ADDR_SIZE constant.
  - Gray-to-binary and binary-to-Gray functions.
  - pointer-width helper constant PTR_W = ADDR_SIZE+1.
- Sub-module: k_sync_bus_t1, a parametrised SYNC_STAGES-deep, width-N flop chain. It is reused by the read-side twin.
- Binary-to-Gray reuses the existing k_b2g_converter_t1 instance.

Test Plan (ADDR_SIZE=4, AFULL_THRESH=12, SYNC_STAGES=2):
- Reset:
  - Stimulus: hold rst_n low, toggle winc.
  - Response: wptr_gray=0, waddr=0, wfull=0, wlevel=0, wen follows winc.
  - Release rst_n; one winc gives wptr_gray=5'b00001 and wlevel=1.
- Fill with reads idle (rptr_gray=0):
  - Stimulus: 16 back-to-back winc.
  - Response: walmost_full rises after the 12th write; wfull rises after the 16th; wlevel=16, wptr_gray=5'b11000.
  - A 17th winc gives wen=0 and no pointer change.
- Drain release:
  - Stimulus: while full, set rptr_gray=5'b00001.
  - Response: wfull falls exactly 3 clk edges later; wlevel=15; the next winc is accepted.
- Wrap:
  - Stimulus: continuous write/read stream with rptr tracking 4 entries behind, 40 writes.
  - Response: waddr wraps 15->0 twice; wbin wraps 31->0; wlevel stays at 4 or 5; wfull is never asserted.
- Async reset mid-fill:
  - Stimulus: after 9 writes, pulse rst_n low between clock edges.
  - Response: all outputs are 0 immediately, not at the next edge.
- K_WPTR_OVF_EN:
  - Stimulus: when full, apply winc for 1 cycle.
  - Response: wovf=1 and held; wovf_clr gives 0 on the next edge.
  - Stimulus: wovf_clr together with winc while full.
  - Response: wovf stays 1.

Source files
------------

// File: rtl/k_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer blocks (write and read side).
// Holds the default geometry plus Gray/binary conversion helpers.
package k_fifo_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int PTR_W         = ADDR_SIZE_DEF + 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Upper bits are zero for narrower pointers, so the low bits come out exact.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/k_b2g_converter_t1.sv
// Combinational binary-to-Gray converter, parametrised on width.
module k_b2g_converter_t1 #(
    parameter int W = 5
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/k_sync_bus_t1.sv
// Plain flop-chain synchroniser for a Gray-coded bus crossing into clk.
// No logic between stages; every flop clears to zero on rst_n.
module k_sync_bus_t1 #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] rq_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                rq_q[i] <= '0;
            end
        end else begin
            rq_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                rq_q[i] <= rq_q[i-1];
            end
        end
    end

    assign q_o = rq_q[STAGES-1];

endmodule

// File: rtl/k_wptr_full_sync_t3.sv
// Write-side pointer, full/almost-full and level generator for the dual-clock FIFO.
// Optional sticky overflow flag (wovf/wovf_clr) is built when K_WPTR_OVF_EN is defined.
module k_wptr_full_sync_t3
    import k_fifo_pkg::*;
#(
    parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
    parameter int AFULL_THRESH = 12,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   rptr_gray,
    output logic                 wen,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr_gray,
    output logic                 wfull,
    output logic                 walmost_full,
`ifdef K_WPTR_OVF_EN
    output logic                 wovf,
    input  logic                 wovf_clr,
`endif
    output logic [ADDR_SIZE:0]   wlevel
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rq_sync, rbin_sync, full_cmp;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          accept;

    assign accept = winc & ~wfull_q;
    assign wbin_d = wbin_q + {{(PW-1){1'b0}}, accept};

    k_b2g_converter_t1 #(
        .W(PW)
    ) u_b2g (
        .bin_i (wbin_d),
        .gray_o(wgray_d)
    );

    k_sync_bus_t1 #(
        .WIDTH (PW),
        .STAGES(SYNC_STAGES)
    ) u_rptr_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rptr_gray),
        .q_o  (rq_sync)
    );

    // Full when the next write pointer laps the synchronised read pointer:
    // top two Gray bits inverted, the rest equal.
    assign rbin_sync = PW'(gray2bin(32'(rq_sync)));
    assign full_cmp  = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
    assign wlevel_d  = wbin_d - rbin_sync;
    assign wfull_d   = (wgray_d == full_cmp);
    assign wafull_d  = (wlevel_d >= PW'(AFULL_THRESH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
        end
    end

`ifdef K_WPTR_OVF_EN
    logic wovf_q, wovf_d;

    // A new overflow takes priority over a clear in the same cycle.
    assign wovf_d = (winc & wfull_q) | (wovf_q & ~wovf_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wovf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_d;
        end
    end

    assign wovf = wovf_q;
`endif

    assign wen          = accept;
    assign waddr        = wbin_q[ADDR_SIZE-1:0];
    assign wptr_gray    = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;

endmodule

// File: tb/tb_k_wptr_full_sync_t3.sv
// Directed bench for k_wptr_full_sync_t3 at ADDR_SIZE=4, AFULL_THRESH=12, SYNC_STAGES=2.
// The overflow scenario is included when K_WPTR_OVF_EN is defined.
module tb_k_wptr_full_sync_t3;

    logic       clk;
    logic       rst_n;
    logic       winc;
    logic [4:0] rptr_gray;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
`ifdef K_WPTR_OVF_EN
    logic       wovf;
    logic       wovf_clr;
`endif

    int errors = 0;
    int checks = 0;

    k_wptr_full_sync_t3 #(
        .ADDR_SIZE   (4),
        .AFULL_THRESH(12),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .winc        (winc),
        .rptr_gray   (rptr_gray),
        .wen         (wen),
        .waddr       (waddr),
        .wptr_gray   (wptr_gray),
        .wfull       (wfull),
        .walmost_full(walmost_full),
`ifdef K_WPTR_OVF_EN
        .wovf        (wovf),
        .wovf_clr    (wovf_clr),
`endif
        .wlevel      (wlevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        winc      = 1'b0;
        rptr_gray = 5'd0;
`ifdef K_WPTR_OVF_EN
        wovf_clr  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            winc = 1'b1;
            @(posedge clk);
            #1;
        end
        winc = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        winc      = 1'b0;
        rptr_gray = 5'd0;
`ifdef K_WPTR_OVF_EN
        wovf_clr  = 1'b0;
`endif
        @(posedge clk);
        #1;
        checks++; if (wptr_gray !== 5'd0) begin errors++; $display("FAIL reset_wptr_gray: got %b expected 00000", wptr_gray); end
        checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got %b expected 0", wfull); end
        checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL reset_wlevel: got %0d expected 0", wlevel); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_walmost_full: got %b expected 0", walmost_full); end
        winc = 1'b1;
        #1;
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL reset_wen_high: got %b expected 1", wen); end
        @(posedge clk);
        #1;
        checks++; if (wptr_gray !== 5'd0) begin errors++; $display("FAIL reset_hold_ptr: got %b expected 00000", wptr_gray); end
        winc = 1'b0;
        #1;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen_low: got %b expected 0", wen); end
        rst_n = 1'b1;
        winc  = 1'b1;
        @(posedge clk);
        #1;
        winc = 1'b0;
        checks++; if (wptr_gray !== 5'b00001) begin errors++; $display("FAIL first_write_gray: got %b expected 00001", wptr_gray); end
        checks++; if (wlevel !== 5'd1) begin errors++; $display("FAIL first_write_level: got %0d expected 1", wlevel); end
        checks++; if (waddr !== 4'd1) begin errors++; $display("FAIL first_write_waddr: got %0d expected 1", waddr); end
    endtask

    task automatic test_fill();
        logic       exp_af;
        logic       exp_full;
        logic [4:0] exp_lvl;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            winc = 1'b1;
            #1;
            checks++; if (wen !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d]: got %b expected 1", i, wen); end
            @(posedge clk);
            #1;
            exp_lvl  = 5'(i);
            exp_af   = (i >= 12);
            exp_full = (i >= 16);
            checks++; if (wlevel !== exp_lvl) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, wlevel, exp_lvl); end
            checks++; if (walmost_full !== exp_af) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, walmost_full, exp_af); end
            checks++; if (wfull !== exp_full) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, wfull, exp_full); end
        end
        winc = 1'b0;
        checks++; if (wptr_gray !== 5'b11000) begin errors++; $display("FAIL fill_gray: got %b expected 11000", wptr_gray); end
        winc = 1'b1;
        #1;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL overfill_wen: got %b expected 0", wen); end
        @(posedge clk);
        #1;
        winc = 1'b0;
        checks++; if (wptr_gray !== 5'b11000) begin errors++; $display("FAIL overfill_gray: got %b expected 11000", wptr_gray); end
        checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL overfill_waddr: got %0d expected 0", waddr); end
        checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL overfill_level: got %0d expected 16", wlevel); end
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL overfill_full: got %b expected 1", wfull); end
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_drain();
        logic exp_full;
        winc      = 1'b0;
        rptr_gray = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            exp_full = (e < 3);
            checks++; if (wfull !== exp_full) begin errors++; $display("FAIL drain_full_edge%0d: got %b expected %b", e, wfull, exp_full); end
        end
        checks++; if (wlevel !== 5'd15) begin errors++; $display("FAIL drain_level: got %0d expected 15", wlevel); end
        winc = 1'b1;
        #1;
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL drain_wen: got %b expected 1", wen); end
        @(posedge clk);
        #1;
        winc = 1'b0;
        checks++; if (wptr_gray !== 5'b11001) begin errors++; $display("FAIL drain_gray: got %b expected 11001", wptr_gray); end
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL drain_refull: got %b expected 1", wfull); end
    endtask

    task automatic test_wrap();
        logic [3:0] prev_addr;
        logic [4:0] prev_gray;
        int addr_wraps;
        int gray_wraps;
        int bad_level;
        int saw_full;
        addr_wraps = 0;
        gray_wraps = 0;
        bad_level  = 0;
        saw_full   = 0;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            rptr_gray = gray5((n >= 1) ? n - 1 : 0);
            winc      = 1'b1;
            prev_addr = waddr;
            prev_gray = wptr_gray;
            @(posedge clk);
            #1;
            if (prev_addr == 4'd15 && waddr == 4'd0) addr_wraps++;
            if (prev_gray == 5'b10000 && wptr_gray == 5'b00000) gray_wraps++;
            if (wfull) saw_full++;
            if (n >= 3 && (wlevel < 5'd4 || wlevel > 5'd5)) bad_level++;
        end
        winc = 1'b0;
        checks++; if (addr_wraps !== 2) begin errors++; $display("FAIL wrap_waddr_count: got %0d expected 2", addr_wraps); end
        checks++; if (gray_wraps !== 1) begin errors++; $display("FAIL wrap_ptr_count: got %0d expected 1", gray_wraps); end
        checks++; if (saw_full !== 0) begin errors++; $display("FAIL wrap_full_seen: got %0d expected 0", saw_full); end
        checks++; if (bad_level !== 0) begin errors++; $display("FAIL wrap_level_range: got %0d bad cycles expected 0", bad_level); end
        checks++; if (waddr !== 4'd8) begin errors++; $display("FAIL wrap_final_waddr: got %0d expected 8", waddr); end
        checks++; if (wptr_gray !== 5'b01100) begin errors++; $display("FAIL wrap_final_gray: got %b expected 01100", wptr_gray); end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_n(9);
        checks++; if (wlevel !== 5'd9) begin errors++; $display("FAIL amid_pre_level: got %0d expected 9", wlevel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wptr_gray !== 5'd0) begin errors++; $display("FAIL amid_gray: got %b expected 00000", wptr_gray); end
        checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL amid_waddr: got %0d expected 0", waddr); end
        checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL amid_level: got %0d expected 0", wlevel); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL amid_full: got %b expected 0", wfull); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL amid_afull: got %b expected 0", walmost_full); end
        rst_n = 1'b1;
    endtask

`ifdef K_WPTR_OVF_EN
    task automatic test_ovf();
        do_reset();
        write_n(16);
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL ovf_initial: got %b expected 0", wovf); end
        winc = 1'b1;
        @(posedge clk);
        #1;
        winc = 1'b0;
        checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", wovf); end
        @(posedge clk);
        #1;
        checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", wovf); end
        wovf_clr = 1'b1;
        @(posedge clk);
        #1;
        wovf_clr = 1'b0;
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", wovf); end
        winc = 1'b1;
        @(posedge clk);
        #1;
        wovf_clr = 1'b1;
        @(posedge clk);
        #1;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", wovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_async_reset();
`ifdef K_WPTR_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
